systolic_sequencer: RTL and testbench

Controller that sequences one NxN output-stationary systolic MAC array. It holds the A and B operand tiles in internal buffers loaded through a simple write port. On `start` it clears the array accumulators, then streams A rows and B columns into the array edges with the diagonal (wavefront) skew the array requires. It holds the array enabled through the drain window and pulses `done` when the array's C outputs are final.

---
 rtl/systolic_sequencer.sv | 132 +++++++++++++
 tb/tb_systolic_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: operand tile buffers and wavefront feed sequencer for one NxN output-stationary MAC array
// Ports:
//   clk, rst                                   clock, synchronous active-low reset
//   load_en, load_sel, load_addr, load_data    tile write port (A when load_sel=0, B when 1), row-major address
//   load_ready                                 high while idle; writes are accepted only then
//   start, busy, done                          run request, run in progress, one-cycle completion pulse
//   arr_clear, arr_en                          array accumulator clear and advance/accumulate enable
//   a_lane, b_lane                             skewed west/north edge operands, lane i at [i*DW +: DW]
module systolic_sequencer #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int DRAIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic                   load_sel,
    input  logic [$clog2(N*N)-1:0] load_addr,
    input  logic [DW-1:0]          load_data,
    output logic                   load_ready,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_clear,
    output logic                   arr_en,
    output logic [N*DW-1:0]        a_lane,
    output logic [N*DW-1:0]        b_lane
);
    localparam int AW   = $clog2(N*N);
    localparam int CMAX = (3*N > DRAIN) ? 3*N : DRAIN + 1;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] LAST_T = CW'(3*N - 3);
    localparam logic [CW-1:0] LAST_D = CW'(DRAIN - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   a_q [N*N];
    logic [DW-1:0]   b_q [N*N];
    logic            load_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            clear_q;
    logic            en_q;
    logic [N*DW-1:0] a_lane_q;
    logic [N*DW-1:0] b_lane_q;
    logic [N*DW-1:0] a_lane_d;
    logic [N*DW-1:0] b_lane_d;
    logic            feed_go;
    logic [CW-1:0]   feed_t;

    // Lanes are registered, so they are decoded from the feed step the array will see next cycle.
    assign feed_go = state_q == S_CLEAR || (state_q == S_FEED && cnt_q != LAST_T);
    assign feed_t  = state_q == S_CLEAR ? '0 : cnt_q + 1'b1;

    // Lane i carries element k of its row/column at step t = i + k, giving the diagonal wavefront.
    always_comb begin
        a_lane_d = '0;
        b_lane_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (feed_go && feed_t == CW'(i + k)) begin
                    a_lane_d[i*DW +: DW] = a_q[AW'(i*N + k)];
                    b_lane_d[i*DW +: DW] = b_q[AW'(k*N + i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '{default: '0};
            b_q          <= '{default: '0};
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            clear_q      <= 1'b0;
            en_q         <= 1'b0;
            a_lane_q     <= '0;
            b_lane_q     <= '0;
        end else begin
            a_lane_q <= a_lane_d;
            b_lane_q <= b_lane_d;
            case (state_q)
                S_IDLE: begin
                    if (load_en && !load_sel) a_q[load_addr] <= load_data;
                    if (load_en && load_sel) b_q[load_addr] <= load_data;
                    if (start) begin
                        state_q      <= S_CLEAR;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                        clear_q      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_FEED;
                    cnt_q   <= '0;
                    clear_q <= 1'b0;
                    en_q    <= 1'b1;
                end
                S_FEED: begin
                    state_q <= cnt_q == LAST_T ? S_DRAIN : S_FEED;
                    cnt_q   <= cnt_q == LAST_T ? '0 : cnt_q + 1'b1;
                end
                S_DRAIN: begin
                    state_q <= cnt_q == LAST_D ? S_DONE : S_DRAIN;
                    cnt_q   <= cnt_q == LAST_D ? '0 : cnt_q + 1'b1;
                    en_q    <= cnt_q != LAST_D;
                    done_q  <= cnt_q == LAST_D;
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign arr_clear  = clear_q;
    assign arr_en     = en_q;
    assign a_lane     = a_lane_q;
    assign b_lane     = b_lane_q;
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: scoreboard bench driving systolic_sequencer into a behavioural MAC array
module tb_systolic_sequencer;
    localparam int N = 4;
    localparam int DW = 16;
    localparam int DRAIN = 2;
    localparam int NN = N * N;

    typedef struct packed { logic [63:0] a; logic [63:0] b; } lane_t;
    typedef struct packed { int cyc; logic [NN*48-1:0] c; } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic        load_sel = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        start = 1'b0;
    logic        load_ready, busy, done, arr_clear, arr_en;
    logic [63:0] a_lane, b_lane;

    systolic_sequencer #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
        .start(start), .busy(busy), .done(done), .arr_clear(arr_clear),
        .arr_en(arr_en), .a_lane(a_lane), .b_lane(b_lane)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [15:0] ma [NN];
    logic [15:0] mb [NN];

    // Behavioural output-stationary array: a moves east, b moves south, each PE accumulates a*b.
    logic [47:0] acc [N][N];
    logic [15:0] ah [N][N];
    logic [15:0] bv [N][N];

    function automatic logic [15:0] a_in(int i, int j);
        if (j == 0) return a_lane[i*DW +: DW];
        return ah[i][j-1];
    endfunction

    function automatic logic [15:0] b_in(int i, int j);
        if (i == 0) return b_lane[j*DW +: DW];
        return bv[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!rst || arr_clear) begin
                    acc[i][j] <= '0;
                    ah[i][j]  <= '0;
                    bv[i][j]  <= '0;
                end else if (arr_en) begin
                    acc[i][j] <= acc[i][j] + 48'(a_in(i, j)) * 48'(b_in(i, j));
                    ah[i][j]  <= a_in(i, j);
                    bv[i][j]  <= b_in(i, j);
                end
            end
        end
    end

    function automatic logic [63:0] lane_a(int t);
        logic [63:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i*N + t - i];
        return v;
    endfunction

    function automatic logic [63:0] lane_b(int t);
        logic [63:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[(t - j)*N + j];
        return v;
    endfunction

    function automatic logic [NN*48-1:0] ref_c();
        logic [NN*48-1:0] v = '0;
        logic [47:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s += 48'(ma[i*N + k]) * 48'(mb[k*N + j]);
                v[(i*N + j)*48 +: 48] = s;
            end
        end
        return v;
    endfunction

    lane_t exp_lane[$];
    done_t exp_done[$];
    int    exp_clr[$];

    task automatic push_run(int e);
        exp_clr.push_back(e + 1);
        for (int t = 0; t < 3*N - 2; t++) exp_lane.push_back('{lane_a(t), lane_b(t)});
        for (int d = 0; d < DRAIN; d++) exp_lane.push_back('{64'h0, 64'h0});
        exp_done.push_back('{e + 3*N + DRAIN, ref_c()});
    endtask

    // Monitor: pops expectations whenever the DUT presents clear, enabled lanes or done.
    always @(negedge clk) begin
        lane_t l;
        done_t d;
        if (arr_clear) begin
            if (exp_clr.size() == 0) chk("clear_unexpected", 1, 0);
            else chk("clear_cycle", 64'(cyc + 1), 64'(exp_clr.pop_front()));
        end
        if (arr_en) begin
            if (exp_lane.size() == 0) chk("arr_en_unexpected", 1, 0);
            else begin
                l = exp_lane.pop_front();
                chk("a_lane", a_lane, l.a);
                chk("b_lane", b_lane, l.b);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                d = exp_done.pop_front();
                chk("done_cycle", 64'(cyc + 1), 64'(d.cyc));
                chk("busy_at_done", 64'(busy), 1);
                chk("load_ready_at_done", 64'(load_ready), 0);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        chk($sformatf("c%0d%0d", i, j), 64'(acc[i][j]), 64'(d.c[(i*N + j)*48 +: 48]));
            end
        end
    end

    task automatic check_reset(string p);
        chk({p, "_busy"}, 64'(busy), 0);
        chk({p, "_done"}, 64'(done), 0);
        chk({p, "_arr_clear"}, 64'(arr_clear), 0);
        chk({p, "_arr_en"}, 64'(arr_en), 0);
        chk({p, "_a_lane"}, a_lane, 0);
        chk({p, "_b_lane"}, b_lane, 0);
        chk({p, "_load_ready"}, 64'(load_ready), 1);
    endtask

    task automatic load(logic sel, int addr, logic [15:0] data);
        load_en = 1'b1;
        load_sel = sel;
        load_addr = 4'(addr);
        load_data = data;
        if (sel) mb[addr] = data;
        else ma[addr] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic start_run(output int e);
        e = cyc + 1;
        push_run(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_done.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d required busy=0 pending=0", busy, exp_done.size());
        end
        chk("lanes_pending", 64'(exp_lane.size()), 0);
        chk("idle_load_ready", 64'(load_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        for (int i = 0; i < NN; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset("init");
        rst = 1'b1;
        for (int i = 0; i < NN; i++) load(1'b0, i, 16'(i + 1));
        for (int i = 0; i < NN; i++) load(1'b1, i, (i % 5 == 0) ? 16'd1 : 16'd0);
        // A = 1..16, B = identity: C = A, lanes checked per feed step
        start_run(e);
        wait_idle();
        // start and a write at FEED t=2 must both be ignored
        start_run(e);
        while (cyc < e + 3) @(negedge clk);
        start = 1'b1;
        load_en = 1'b1;
        load_sel = 1'b0;
        load_addr = '0;
        load_data = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        load_en = 1'b0;
        wait_idle();
        start_run(e);
        wait_idle();
        // write A[0][0]=5 in the same cycle as start
        load_en = 1'b1;
        load_sel = 1'b0;
        load_addr = '0;
        load_data = 16'd5;
        ma[0] = 16'd5;
        start_run(e);
        load_en = 1'b0;
        wait_idle();
        // reset sampled at cycle 6, then a run on the cleared buffers
        start_run(e);
        while (cyc < e + 5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("midrun");
        exp_lane.delete();
        exp_done.delete();
        exp_clr.delete();
        for (int i = 0; i < NN; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        start_run(e);
        wait_idle();
        // reload and hold start high: runs complete at cycles 14 and 29 only
        for (int i = 0; i < NN; i++) load(1'b0, i, 16'(3*i + 2));
        for (int i = 0; i < NN; i++) load(1'b1, i, 16'(i ^ 5));
        e = cyc + 1;
        push_run(e);
        push_run(e + 3*N + DRAIN + 1);
        start = 1'b1;
        while (cyc < e + 3*N + DRAIN + 1) @(negedge clk);
        start = 1'b0;
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
